fp_mul_round_stage: RTL and testbench

- Downstream normalize-and-round back end for the 32-bit IEEE-754 single-precision multiplier.
- Consumes the raw 48-bit significand product, product sign, pre-normalised biased exponent and special-case flags from the multiplier core.
- Produces the packed fp_Z result with ovrf/udrf/inexact flags.
- Two-stage pipeline (normalise, then round/pack) with valid/ready handshake on both sides.

---
 rtl/fp_mul_pkg.sv | 44 ++++
 rtl/fp_round_incr.sv | 28 ++
 rtl/fp_mul_round_stage.sv | 185 ++++++++++++++++++
 tb/tb_fp_mul_round_stage.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/fp_mul_pkg.sv
// rtl/fp_mul_pkg.sv - shared types and constants for the fp32 multiplier round back end
package fp_mul_pkg;

  localparam int SIG_W  = 24;
  localparam int EXPI_W = 10;

  localparam int          FP_BIAS   = 127;
  localparam logic [31:0] FP_QNAN   = 32'h7FC0_0000;
  localparam logic [30:0] FP_MAXFIN = 31'h7F7F_FFFF;
  localparam int          EXP_MAX   = 255;

  typedef enum logic [2:0] {
    RM_RNE = 3'd0,
    RM_RTZ = 3'd1,
    RM_RDN = 3'd2,
    RM_RUP = 3'd3,
    RM_RMM = 3'd4
  } rmode_e;

  // exp carries one extra bit so that in_exp+1 can never wrap
  typedef struct packed {
    logic                  sign;
    logic signed [EXPI_W:0] exp;
    logic [SIG_W-1:0]      sig;
    logic                  g;
    logic                  r;
    logic                  s;
    rmode_e                mode;
    logic                  nan;
    logic                  inf;
    logic                  zero;
  } s1_t;

  function automatic rmode_e decode_mode(input logic [2:0] m);
    case (m)
      3'd1:    return RM_RTZ;
      3'd2:    return RM_RDN;
      3'd3:    return RM_RUP;
      3'd4:    return RM_RMM;
      default: return RM_RNE;
    endcase
  endfunction

endpackage

// File: rtl/fp_round_incr.sv
// rtl/fp_round_incr.sv - round-up decision from mode, sign, lsb and guard/round/sticky
module fp_round_incr
  import fp_mul_pkg::*;
(
  input  rmode_e mode_i,
  input  logic   sign_i,
  input  logic   lsb_i,
  input  logic   g_i,
  input  logic   r_i,
  input  logic   s_i,
  output logic   inc_o
);

  logic any_lost;
  assign any_lost = g_i | r_i | s_i;

  always_comb begin
    inc_o = 1'b0;
    case (mode_i)
      RM_RTZ:  inc_o = 1'b0;
      RM_RDN:  inc_o = sign_i & any_lost;
      RM_RUP:  inc_o = ~sign_i & any_lost;
      RM_RMM:  inc_o = g_i;
      default: inc_o = g_i & (r_i | s_i | lsb_i);
    endcase
  end

endmodule

// File: rtl/fp_mul_round_stage.sv
// rtl/fp_mul_round_stage.sv - two-stage normalise + round/pack back end for the fp32 multiplier
// FP_MUL_SUBNORMAL_EN: produce gradual-underflow subnormals instead of flushing to zero
module fp_mul_round_stage
  import fp_mul_pkg::*;
#(
  parameter int MANT_W = 24,
  parameter int EXP_W  = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_sign,
  input  logic [EXP_W-1:0]      in_exp,
  input  logic [2*MANT_W-1:0]   in_mant,
  input  logic                  in_nan,
  input  logic                  in_inf,
  input  logic                  in_zero,
  input  logic [2:0]            r_mode,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [31:0]           fp_Z,
  output logic                  ovrf,
  output logic                  udrf,
  output logic                  inexact
);

  localparam logic signed [EXPI_W:0] E_ZERO = '0;
  localparam logic signed [EXPI_W:0] E_MAXV = (EXPI_W+1)'(EXP_MAX);

  s1_t         s1_d, s1_q;
  logic        v1_q, v2_q;
  logic        ready1, ready2;
  logic [31:0] z_d, z_q;
  logic        ovrf_d, ovrf_q, udrf_d, udrf_q, inex_d, inex_q;

  assign ready2   = ~v2_q | out_ready;
  assign ready1   = ~v1_q | ready2;
  assign in_ready = ready1;

  always_comb begin
    s1_d      = '0;
    s1_d.sign = in_sign;
    s1_d.mode = decode_mode(r_mode);
    s1_d.nan  = in_nan;
    s1_d.inf  = in_inf;
    s1_d.zero = in_zero;
    if (in_mant[2*MANT_W-1]) begin
      s1_d.sig = in_mant[2*MANT_W-1 -: MANT_W];
      s1_d.g   = in_mant[MANT_W-1];
      s1_d.r   = in_mant[MANT_W-2];
      s1_d.s   = |in_mant[MANT_W-3:0];
      s1_d.exp = {in_exp[EXP_W-1], in_exp} + {{EXP_W{1'b0}}, 1'b1};
    end else begin
      s1_d.sig = in_mant[2*MANT_W-2 -: MANT_W];
      s1_d.g   = in_mant[MANT_W-2];
      s1_d.r   = in_mant[MANT_W-3];
      s1_d.s   = |in_mant[MANT_W-4:0];
      s1_d.exp = {in_exp[EXP_W-1], in_exp};
    end
  end

  logic signed [EXPI_W:0] e1;
  logic                   tiny;
  logic                   hid, rg, rr, rs, inc, frac_c, to_inf;
  logic [SIG_W-2:0]       rfrac;
  logic [SIG_W-1:0]       fsum;
  logic signed [EXPI_W:0] exp_r;

  assign e1   = s1_q.exp;
  assign tiny = (e1 <= E_ZERO);

`ifdef FP_MUL_SUBNORMAL_EN
  localparam logic signed [EXPI_W:0] E_ONE    = (EXPI_W+1)'(1);
  localparam logic signed [EXPI_W:0] E_SUBLIM = -(EXPI_W+1)'(25);

  logic [5:0]  sh_amt;
  logic [51:0] sh_vec;

  // Below -24 every significand bit lands in sticky; a 26-bit shift does exactly that
  always_comb begin
    sh_amt = (e1 < E_SUBLIM) ? 6'd26 : 6'(E_ONE - e1);
    sh_vec = {s1_q.sig, s1_q.g, s1_q.r, 26'b0} >> sh_amt;
  end
`endif

  always_comb begin
    hid   = s1_q.sig[SIG_W-1];
    rfrac = s1_q.sig[SIG_W-2:0];
    rg    = s1_q.g;
    rr    = s1_q.r;
    rs    = s1_q.s;
`ifdef FP_MUL_SUBNORMAL_EN
    if (tiny) begin
      hid   = sh_vec[51];
      rfrac = sh_vec[50:28];
      rg    = sh_vec[27];
      rr    = sh_vec[26];
      rs    = s1_q.s | (|sh_vec[25:0]);
    end
`endif
  end

  fp_round_incr u_incr (
    .mode_i (s1_q.mode),
    .sign_i (s1_q.sign),
    .lsb_i  (rfrac[0]),
    .g_i    (rg),
    .r_i    (rr),
    .s_i    (rs),
    .inc_o  (inc)
  );

  // A fraction carry either renormalises (hidden set) or promotes a subnormal to min normal
  always_comb begin
    fsum   = {1'b0, rfrac} + {{(SIG_W-1){1'b0}}, inc};
    frac_c = fsum[SIG_W-1];
    exp_r  = e1 + {{EXPI_W{1'b0}}, hid & frac_c};
    to_inf = (s1_q.mode == RM_RNE) || (s1_q.mode == RM_RMM) ||
             ((s1_q.mode == RM_RDN) && s1_q.sign) ||
             ((s1_q.mode == RM_RUP) && !s1_q.sign);

    z_d    = '0;
    ovrf_d = 1'b0;
    udrf_d = 1'b0;
    inex_d = 1'b0;
    if (s1_q.nan) begin
      z_d = FP_QNAN;
    end else if (s1_q.inf) begin
      z_d = {s1_q.sign, 8'hFF, 23'b0};
    end else if (s1_q.zero) begin
      z_d = {s1_q.sign, 31'b0};
    end else if (tiny) begin
`ifdef FP_MUL_SUBNORMAL_EN
      z_d    = {s1_q.sign, 7'b0, hid | frac_c, fsum[SIG_W-2:0]};
      inex_d = rg | rr | rs;
      udrf_d = rg | rr | rs;
`else
      z_d    = {s1_q.sign, 31'b0};
      inex_d = 1'b1;
      udrf_d = 1'b1;
`endif
    end else if (exp_r >= E_MAXV) begin
      ovrf_d = 1'b1;
      inex_d = 1'b1;
      z_d    = to_inf ? {s1_q.sign, 8'hFF, 23'b0} : {s1_q.sign, FP_MAXFIN};
    end else begin
      z_d    = {s1_q.sign, exp_r[7:0], fsum[SIG_W-2:0]};
      inex_d = rg | rr | rs;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q   <= 1'b0;
      s1_q   <= '0;
      v2_q   <= 1'b0;
      z_q    <= '0;
      ovrf_q <= 1'b0;
      udrf_q <= 1'b0;
      inex_q <= 1'b0;
    end else begin
      if (ready1) begin
        v1_q <= in_valid;
        if (in_valid) s1_q <= s1_d;
      end
      if (ready2) begin
        v2_q <= v1_q;
        if (v1_q) begin
          z_q    <= z_d;
          ovrf_q <= ovrf_d;
          udrf_q <= udrf_d;
          inex_q <= inex_d;
        end
      end
    end
  end

  assign out_valid = v2_q;
  assign fp_Z      = z_q;
  assign ovrf      = ovrf_q;
  assign udrf      = udrf_q;
  assign inexact   = inex_q;

endmodule

// File: tb/tb_fp_mul_round_stage.sv
// tb/tb_fp_mul_round_stage.sv - directed self-checking bench for fp_mul_round_stage
module tb_fp_mul_round_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, in_sign, in_nan, in_inf, in_zero;
  logic [9:0]  in_exp;
  logic [47:0] in_mant;
  logic [2:0]  r_mode;
  logic        out_valid, out_ready, ovrf, udrf, inexact;
  logic [31:0] fp_Z;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fp_mul_round_stage dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sign   (in_sign),
    .in_exp    (in_exp),
    .in_mant   (in_mant),
    .in_nan    (in_nan),
    .in_inf    (in_inf),
    .in_zero   (in_zero),
    .r_mode    (r_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .fp_Z      (fp_Z),
    .ovrf      (ovrf),
    .udrf      (udrf),
    .inexact   (inexact)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic set_in(input logic sg, input int ex, input logic [47:0] mt,
                        input logic [2:0] md, input logic [2:0] spc);
    in_sign = sg;
    in_exp  = 10'(ex);
    in_mant = mt;
    r_mode  = md;
    {in_nan, in_inf, in_zero} = spc;
  endtask

  task automatic run_one(input string tag, input logic sg, input int ex, input logic [47:0] mt,
                         input logic [2:0] md, input logic [2:0] spc, input logic [31:0] ez,
                         input logic eo, input logic eu, input logic ei);
    int n;
    @(negedge clk);
    out_ready = 1'b1;
    set_in(sg, ex, mt, md, spc);
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    n = 0;
    do begin
      @(posedge clk);
      #1 n++;
    end while (!out_valid && n < 5);
    check({tag, "_lat"}, 32'(n), 32'd1);
    check({tag, "_z"}, fp_Z, ez);
    check({tag, "_ovrf"}, {31'b0, ovrf}, {31'b0, eo});
    check({tag, "_udrf"}, {31'b0, udrf}, {31'b0, eu});
    check({tag, "_inexact"}, {31'b0, inexact}, {31'b0, ei});
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    set_in(1'b0, 0, 48'h0, 3'd0, 3'b000);
    repeat (3) @(negedge clk);
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_fp_Z", fp_Z, 32'h0);
    check("rst_flags", {29'b0, ovrf, udrf, inexact}, 32'd0);
    rst_n = 1'b1;

    run_one("mul15", 1'b0, 127, 48'h900000000000, 3'd0, 3'b000, 32'h40100000, 0, 0, 0);
    run_one("tie_rne", 1'b0, 127, 48'h400000400000, 3'd0, 3'b000, 32'h3F800000, 0, 0, 1);
    run_one("tie_rmm", 1'b0, 127, 48'h400000400000, 3'd4, 3'b000, 32'h3F800001, 0, 0, 1);
    run_one("tie_rdn_neg", 1'b1, 127, 48'h400000400000, 3'd2, 3'b000, 32'hBF800001, 0, 0, 1);
    run_one("tie_rup_neg", 1'b1, 127, 48'h400000400000, 3'd3, 3'b000, 32'hBF800000, 0, 0, 1);
    run_one("tie_rtz", 1'b0, 127, 48'h400000400000, 3'd1, 3'b000, 32'h3F800000, 0, 0, 1);
    run_one("tie_odd_m7", 1'b0, 127, 48'h400000C00000, 3'd7, 3'b000, 32'h3F800002, 0, 0, 1);
    run_one("carry", 1'b0, 126, 48'hFFFFFFFFFFFF, 3'd0, 3'b000, 32'h40000000, 0, 0, 1);
    run_one("ovf_rtz", 1'b0, 254, 48'h800000000000, 3'd1, 3'b000, 32'h7F7FFFFF, 1, 0, 1);
    run_one("ovf_rne", 1'b0, 254, 48'h800000000000, 3'd0, 3'b000, 32'h7F800000, 1, 0, 1);
    run_one("ovf_rup_neg", 1'b1, 254, 48'h800000000000, 3'd3, 3'b000, 32'hFF7FFFFF, 1, 0, 1);
    run_one("ovf_rdn_neg", 1'b1, 254, 48'h800000000000, 3'd2, 3'b000, 32'hFF800000, 1, 0, 1);
    run_one("min_norm", 1'b0, 1, 48'h400000000000, 3'd0, 3'b000, 32'h00800000, 0, 0, 0);
`ifdef FP_MUL_SUBNORMAL_EN
    run_one("uf_pos", 1'b0, -5, 48'h400000000000, 3'd0, 3'b000, 32'h00020000, 0, 0, 0);
    run_one("uf_neg", 1'b1, -5, 48'h400000000000, 3'd3, 3'b000, 32'h80020000, 0, 0, 0);
    run_one("uf_deep_rup", 1'b0, -40, 48'h400000000000, 3'd3, 3'b000, 32'h00000001, 0, 1, 1);
`else
    run_one("uf_pos", 1'b0, -5, 48'h400000000000, 3'd0, 3'b000, 32'h00000000, 0, 1, 1);
    run_one("uf_neg", 1'b1, -5, 48'h400000000000, 3'd3, 3'b000, 32'h80000000, 0, 1, 1);
    run_one("uf_deep_rup", 1'b0, -40, 48'h400000000000, 3'd3, 3'b000, 32'h00000000, 0, 1, 1);
`endif
    run_one("nan_prio", 1'b1, 254, 48'h800000000000, 3'd0, 3'b111, 32'h7FC00000, 0, 0, 0);
    run_one("inf_neg", 1'b1, 127, 48'h900000000000, 3'd0, 3'b011, 32'hFF800000, 0, 0, 0);
    run_one("zero_neg", 1'b1, 127, 48'h900000000000, 3'd0, 3'b001, 32'h80000000, 0, 0, 0);

    // Stall: three back-to-back products, r_mode changes behind each accept
    @(posedge clk);
    #1 out_ready = 1'b0;
    set_in(1'b0, 127, 48'h400000400000, 3'd4, 3'b000);
    in_valid = 1'b1;
    @(posedge clk);
    #1 set_in(1'b0, 127, 48'h400000400000, 3'd0, 3'b000);
    @(posedge clk);
    #1 check("stall_in_ready", {31'b0, in_ready}, 32'd0);
    check("stall_out_valid", {31'b0, out_valid}, 32'd1);
    check("stall_a_z", fp_Z, 32'h3F800001);
    set_in(1'b0, 127, 48'h900000000000, 3'd1, 3'b000);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1 check("stall_hold_z", fp_Z, 32'h3F800001);
    end
    check("stall_hold_in_ready", {31'b0, in_ready}, 32'd0);
    out_ready = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    check("drain_b_valid", {31'b0, out_valid}, 32'd1);
    check("drain_b_z", fp_Z, 32'h3F800000);
    @(posedge clk);
    #1 check("drain_c_valid", {31'b0, out_valid}, 32'd1);
    check("drain_c_z", fp_Z, 32'h40100000);
    @(posedge clk);
    #1 check("drain_empty", {31'b0, out_valid}, 32'd0);

    // Reset pulse while two products sit stalled in the pipe
    out_ready = 1'b0;
    set_in(1'b0, 254, 48'h800000000000, 3'd1, 3'b000);
    in_valid = 1'b1;
    @(posedge clk);
    #1 set_in(1'b0, 127, 48'h900000000000, 3'd0, 3'b000);
    @(posedge clk);
    #1 in_valid = 1'b0;
    check("pre_rst_z", fp_Z, 32'h7F7FFFFF);
    check("pre_rst_ovrf", {31'b0, ovrf}, 32'd1);
    #2 rst_n = 1'b0;
    #1 check("async_rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("async_rst_in_ready", {31'b0, in_ready}, 32'd1);
    check("async_rst_z", fp_Z, 32'h0);
    check("async_rst_ovrf", {31'b0, ovrf}, 32'd0);
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 check("post_rst_discarded", {31'b0, out_valid}, 32'd0);

    run_one("post_rst_mul15", 1'b0, 127, 48'h900000000000, 3'd0, 3'b000, 32'h40100000, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
